// File: rtl/store_rmw_unit.sv
// store_rmw_unit
//   RV32I store path for a word-wide data memory without byte strobes.
//   SW is written straight through; SB/SH read the aligned word, merge the
//   byte/halfword into its lane, and write the merged word back. Misaligned
//   or illegal requests complete with st_err and never touch memory.
//
// Handshakes:
//   st_valid/st_ready : request accepted on a cycle where both are high;
//                       st_ready is high only in IDLE. The requester holds
//                       the request until it is accepted.
//   mem_re/mem_rvalid : mem_re is a one-cycle pulse; read data arrives on
//                       any later cycle with mem_rvalid (no timeout).
//   mem_we/mem_wack   : mem_we, mem_addr and mem_wdata are held until the
//                       cycle mem_wack is seen, including the first WR cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   st_valid, st_ready    request handshake
//   funct, addr, st_data  store funct3, byte address, rs2 value
//   st_done, st_err       one-cycle completion pulse and error flag
//   mem_addr              word-aligned memory address
//   mem_re, mem_rdata, mem_rvalid   read channel
//   mem_we, mem_wdata, mem_wack     write channel
//   dbg_state             current FSM state for observation
module store_rmw_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        funct,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] F_SB = 3'b000;
    localparam logic [2:0] F_SH = 3'b001;
    localparam logic [2:0] F_SW = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct_q, funct_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       data_q, data_d;   // only the low halfword can be merged
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              legal;
    logic [31:0]       merged;

    // Alignment/funct legality of the incoming request.
    always_comb begin
        legal = 1'b0;
        case (funct)
            F_SB:    legal = 1'b1;
            F_SH:    legal = ~addr[0];
            F_SW:    legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Lane merge of the registered store data into the word just read.
    always_comb begin
        merged = mem_rdata;
        if (funct_q == F_SB) begin
            case (lane_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        funct_d     = funct_q;
        lane_d      = lane_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    funct_d = funct;
                    lane_d  = addr[1:0];
                    data_d  = st_data[15:0];
                    if (!legal) begin
                        // Illegal requests leave the memory-side registers alone.
                        state_d = S_ERR;
                    end else begin
                        mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                        if (funct == F_SW) begin
                            mem_wdata_d = st_data;
                            state_d     = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD:      state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    mem_wdata_d = merged;
                    state_d     = S_WR;
                end
            end
            S_WR:      if (mem_wack) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            funct_q     <= 3'b000;
            lane_q      <= 2'b00;
            data_q      <= 16'h0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            funct_q     <= funct_d;
            lane_q      <= lane_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign st_ready  = (state_q == S_IDLE);
    assign st_done   = (state_q == S_DONE) || (state_q == S_ERR);
    assign st_err    = (state_q == S_ERR);
    assign mem_re    = (state_q == S_RD);
    assign mem_we    = (state_q == S_WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;

    localparam logic [2:0] F_SB = 3'b000;
    localparam logic [2:0] F_SH = 3'b001;
    localparam logic [2:0] F_SW = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        st_done;
    logic        st_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_wack;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    store_rmw_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .funct(funct), .addr(addr), .st_data(st_data),
        .st_done(st_done), .st_err(st_err), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit ref_err(input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] d, input logic [31:0] old);
        int sh;
        logic [31:0] mask;
        if (f == F_SW) return d;
        if (f == F_SB) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
            return (old & ~mask) | ((d & 32'h0000_00FF) << sh);
        end
        sh   = a[1] ? 16 : 0;
        mask = 32'h0000_FFFF << sh;
        return (old & ~mask) | ((d & 32'h0000_FFFF) << sh);
    endfunction

    // Cycle (counted from the accept cycle = 0) at which st_done is expected.
    function automatic int ref_done_cyc(input logic [2:0] f, input logic [31:0] a,
                                        input int rd_lat, input int wack_lat);
        if (ref_err(f, a)) return 1;
        if (f == F_SW) return 2 + wack_lat;
        return 3 + rd_lat + wack_lat;
    endfunction

    // ---------------- driver: one store with a reactive memory ----------------
    task automatic run_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rdata, input int rd_lat, input int wack_lat,
                             input bit spur,
                             output int o_re, output int o_we,
                             output logic [31:0] o_wdata, output logic [31:0] o_addr,
                             output bit o_stable, output int o_done_cyc, output int o_done_cnt,
                             output bit o_err, output bit o_ready_after, output bit o_timeout);
        int cyc, re_cyc, we_cyc;
        logic [31:0] rd_addr;
        o_re = 0; o_we = 0; o_wdata = 'x; o_addr = 'x; o_stable = 1'b1;
        o_done_cyc = -1; o_done_cnt = 0; o_err = 1'b0; o_ready_after = 1'b0; o_timeout = 1'b0;
        re_cyc = -1; we_cyc = -1; rd_addr = '0;
        @(negedge clk);
        st_valid = 1'b1; funct = f; addr = a; st_data = d;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            st_valid = 1'b0; funct = 3'($urandom); addr = $urandom; st_data = $urandom;
            mem_rvalid = 1'b0; mem_wack = 1'b0; mem_rdata = $urandom;
            if (mem_re) begin
                o_re++; re_cyc = cyc; rd_addr = mem_addr;
            end
            if (re_cyc >= 0 && cyc == re_cyc + rd_lat) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
            end
            if (mem_we) begin
                o_we++;
                if (we_cyc < 0) begin
                    we_cyc = cyc; o_wdata = mem_wdata; o_addr = mem_addr;
                    if (re_cyc >= 0 && rd_addr !== mem_addr) o_stable = 1'b0;
                end else if (mem_wdata !== o_wdata || mem_addr !== o_addr) begin
                    o_stable = 1'b0;
                end
                if (cyc == we_cyc + wack_lat) mem_wack = 1'b1;
            end else if (spur && $urandom_range(0, 1) == 1) begin
                mem_wack = 1'b1;
            end
            if (spur && we_cyc >= 0 && !mem_rvalid) mem_rvalid = 1'($urandom_range(0, 1));
            if (st_done) begin
                o_done_cnt++;
                if (o_done_cyc < 0) begin
                    o_done_cyc = cyc; o_err = st_err;
                end
            end
            if (o_done_cyc >= 0 && cyc == o_done_cyc + 1) o_ready_after = st_ready;
            if (o_done_cyc >= 0 && cyc >= o_done_cyc + 2) break;
            if (cyc >= 80) begin
                o_timeout = 1'b1;
                break;
            end
        end
        mem_rvalid = 1'b0; mem_wack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (st_ready !== 1'b1 || st_done !== 1'b0 || st_err !== 1'b0 ||
            mem_re !== 1'b0 || mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: ready=%b done=%b err=%b re=%b we=%b, required 1 0 0 0 0",
                     st_ready, st_done, st_err, mem_re, mem_we);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data: mem_addr=%h mem_wdata=%h, required 0 0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_sw();
        int re, we, dc, dn; logic [31:0] wd, ad; bit st, er, ra, to;
        run_store(F_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, 1'b0,
                  re, we, wd, ad, st, dc, dn, er, ra, to);
        n_checks++;
        if (re !== 0 || wd !== 32'hDEADBEEF || ad !== 32'h100) begin
            n_errors++;
            $display("FAIL sw_write: re=%0d wdata=%h addr=%h, required 0 deadbeef 00000100", re, wd, ad);
        end
        n_checks++;
        if (to || dc !== 2 || er !== 1'b0 || dn !== 1) begin
            n_errors++;
            $display("FAIL sw_done: cyc=%0d err=%b count=%0d timeout=%b, required 2 0 1 0", dc, er, dn, to);
        end
    endtask

    task automatic test_sb_lanes();
        int re, we, dc, dn; logic [31:0] wd, ad, a, exp; bit st, er, ra, to;
        for (int lane = 0; lane < 4; lane++) begin
            a   = 32'h0000_0300 | 32'(lane);
            exp = ref_word(F_SB, a, 32'hFFFFFFAB, 32'h11223344);
            run_store(F_SB, a, 32'hFFFFFFAB, 32'h11223344, 1, 0, 1'b0,
                      re, we, wd, ad, st, dc, dn, er, ra, to);
            n_checks++;
            if (wd !== exp || ad !== 32'h300 || re !== 1 || dc !== 4 || er !== 1'b0) begin
                n_errors++;
                $display("FAIL sb_lane%0d: wdata=%h addr=%h re=%0d done_cyc=%0d err=%b, required %h 00000300 1 4 0",
                         lane, wd, ad, re, dc, er, exp);
            end
        end
    endtask

    task automatic test_sh_halves();
        int re, we, dc, dn; logic [31:0] wd, ad; bit st, er, ra, to;
        run_store(F_SH, 32'h202, 32'h12345678, 32'hAAAABBBB, 1, 0, 1'b0,
                  re, we, wd, ad, st, dc, dn, er, ra, to);
        n_checks++;
        if (wd !== 32'h5678BBBB || ad !== 32'h200 || dc !== 4) begin
            n_errors++;
            $display("FAIL sh_upper: wdata=%h addr=%h done_cyc=%0d, required 5678bbbb 00000200 4", wd, ad, dc);
        end
        run_store(F_SH, 32'h200, 32'h12345678, 32'hAAAABBBB, 1, 0, 1'b0,
                  re, we, wd, ad, st, dc, dn, er, ra, to);
        n_checks++;
        if (wd !== 32'hAAAA5678 || ad !== 32'h200 || dc !== 4) begin
            n_errors++;
            $display("FAIL sh_lower: wdata=%h addr=%h done_cyc=%0d, required aaaa5678 00000200 4", wd, ad, dc);
        end
    endtask

    task automatic test_errors();
        int re, we, dc, dn; logic [31:0] wd, ad; bit st, er, ra, to;
        logic [2:0]  fs [3];
        logic [31:0] as [3];
        fs[0] = F_SH;   as[0] = 32'h201;
        fs[1] = F_SW;   as[1] = 32'h102;
        fs[2] = 3'b011; as[2] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            run_store(fs[i], as[i], 32'hCAFEF00D, 32'h0, 1, 0, 1'b0,
                      re, we, wd, ad, st, dc, dn, er, ra, to);
            n_checks++;
            if (re !== 0 || we !== 0 || dc !== 1 || er !== 1'b1 || dn !== 1 || ra !== 1'b1) begin
                n_errors++;
                $display("FAIL err_case%0d: re=%0d we=%0d done_cyc=%0d err=%b count=%0d ready_after=%b, required 0 0 1 1 1 1",
                         i, re, we, dc, er, dn, ra);
            end
        end
    endtask

    task automatic test_stalls();
        int re, we, dc, dn; logic [31:0] wd, ad; bit st, er, ra, to;
        run_store(F_SB, 32'h41, 32'h5A, 32'h01020304, 5, 3, 1'b0,
                  re, we, wd, ad, st, dc, dn, er, ra, to);
        n_checks++;
        if (re !== 1 || we !== 4 || !st || dn !== 1) begin
            n_errors++;
            $display("FAIL stall_hold: re=%0d we_cycles=%0d stable=%b done_count=%0d, required 1 4 1 1",
                     re, we, st, dn);
        end
        n_checks++;
        if (wd !== 32'h01025A04 || ad !== 32'h40 || dc !== 11 || to) begin
            n_errors++;
            $display("FAIL stall_result: wdata=%h addr=%h done_cyc=%0d, required 01025a04 00000040 11", wd, ad, dc);
        end
    endtask

    task automatic test_random();
        int re, we, dc, dn, rl, wl; logic [31:0] wd, ad, a, d, old; logic [2:0] f;
        bit st, er, ra, to, e;
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f = 3'($urandom_range(0, 2));
            a   = $urandom; d = $urandom; old = $urandom;
            rl  = $urandom_range(1, 4); wl = $urandom_range(0, 3);
            e   = ref_err(f, a);
            run_store(f, a, d, old, rl, wl, 1'b1, re, we, wd, ad, st, dc, dn, er, ra, to);
            n_checks++;
            if (to || er !== e || dc !== ref_done_cyc(f, a, rl, wl) || dn !== 1 || ra !== 1'b1) begin
                n_errors++;
                $display("FAIL rand%0d_ctrl: f=%0d a=%h err=%b done_cyc=%0d count=%0d ready_after=%b, required err=%b cyc=%0d 1 1",
                         i, f, a, er, dc, dn, ra, e, ref_done_cyc(f, a, rl, wl));
            end
            n_checks++;
            if (e) begin
                if (re !== 0 || we !== 0) begin
                    n_errors++;
                    $display("FAIL rand%0d_noaccess: re=%0d we=%0d, required 0 0", i, re, we);
                end
            end else if (wd !== ref_word(f, a, d, old) || ad !== (a & 32'hFFFF_FFFC) ||
                         re !== ((f == F_SW) ? 0 : 1) || we !== wl + 1 || !st) begin
                n_errors++;
                $display("FAIL rand%0d_data: f=%0d wdata=%h addr=%h re=%0d we=%0d stable=%b, required %h %h re=%0d we=%0d stable=1",
                         i, f, wd, ad, re, we, st, ref_word(f, a, d, old), a & 32'hFFFF_FFFC,
                         (f == F_SW) ? 0 : 1, wl + 1);
            end
        end
    endtask

    task automatic test_reset_midop();
        int re, we, dc, dn; logic [31:0] wd, ad; bit st, er, ra, to, bad;
        // Reset while waiting for read data.
        @(negedge clk);
        st_valid = 1'b1; funct = F_SB; addr = 32'h305; st_data = 32'h77;
        @(negedge clk); st_valid = 1'b0;       // RD
        @(negedge clk);                        // RD_WAIT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (st_ready !== 1'b1 || mem_we !== 1'b0 || st_done !== 1'b0 || mem_re !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_rdwait: ready=%b we=%b done=%b re=%b, required 1 0 0 0",
                     st_ready, mem_we, st_done, mem_re);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (mem_we !== 1'b0 || st_done !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL rst_late_rvalid: write or done seen=%b, required 0", bad);
        end
        // Reset while a write is outstanding.
        @(negedge clk);
        st_valid = 1'b1; funct = F_SW; addr = 32'h500; st_data = 32'h0BADCAFE;
        @(negedge clk); st_valid = 1'b0;       // WR
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_wr_entry: we=%b, required 1", mem_we);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (st_ready !== 1'b1 || mem_we !== 1'b0 || st_done !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_wr: ready=%b we=%b done=%b, required 1 0 0", st_ready, mem_we, st_done);
        end
        mem_wack = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_wack = 1'b0;
            if (st_done !== 1'b0 || mem_we !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL rst_late_wack: activity seen=%b, required 0", bad);
        end
        run_store(F_SW, 32'h600, 32'h13579BDF, 32'h0, 1, 1, 1'b0,
                  re, we, wd, ad, st, dc, dn, er, ra, to);
        n_checks++;
        if (wd !== 32'h13579BDF || ad !== 32'h600 || dc !== 3 || er !== 1'b0 || dn !== 1) begin
            n_errors++;
            $display("FAIL rst_recover: wdata=%h addr=%h done_cyc=%0d err=%b count=%0d, required 13579bdf 00000600 3 0 1",
                     wd, ad, dc, er, dn);
        end
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; funct = 3'b000; addr = '0; st_data = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
        test_reset();
        test_sw();
        test_sb_lanes();
        test_sh_halves();
        test_errors();
        test_stalls();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- RV32I store-side counterpart to the load extraction unit: takes SB/SH/SW requests from the execute stage and writes them to a word-wide data memory that has no byte strobes.
- SB/SH use a read-modify-write sequence: fetch the aligned word, merge the byte or halfword into its lane, then write the word back.
- SW writes directly.
- Misaligned or illegal requests are flagged and make no memory access.

Parameters:
- ADDR_W, 32, byte-address width; memory addresses are word-aligned, with the low 2 bits forced to 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request valid
- st_ready  out  1  unit idle, can accept a request
- funct  in  3  RV32I store funct3: 000 SB, 001 SH, 010 SW; all other values illegal
- addr  in  ADDR_W  byte address of the store
- st_data  in  32  rs2 value; only the low byte/halfword is used for SB/SH
- st_done  out  1  one-cycle pulse when the request completes
- st_err  out  1  valid with st_done; 1 = misaligned or illegal funct
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_re  out  1  read request, one-cycle pulse
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid
- mem_we  out  1  write request, held until acknowledged
- mem_wdata  out  32  write data
- mem_wack  in  1  write accepted

Behaviour:
- States: IDLE, RD, RD_WAIT, WR, DONE, ERR.
- Reset values: state IDLE; st_ready=1 once rst deasserts; st_done, st_err, mem_re, mem_we = 0; mem_addr, mem_wdata = 0.
- Reset mid-operation returns the unit to IDLE on the next edge and abandons the pending memory transaction. The memory side must discard partial transactions on rst.
- Accept: st_valid && st_ready in IDLE. On accept, register funct, addr and st_data. st_ready=0 in every state except IDLE.
- Legality at accept:
  - funct not in {000,001,010} -> ERR.
  - SH with addr[0]=1 -> ERR.
  - SW with addr[1:0]!=0 -> ERR.
  - SB is always aligned.
- ERR: st_done=1 and st_err=1 for one cycle, then IDLE. mem_re and mem_we are never asserted.
- SW: IDLE -> WR, with mem_wdata = st_data.
- SB/SH: IDLE -> RD.
  - RD: mem_re=1 for exactly one cycle, with mem_addr valid. Then go to RD_WAIT.
  - RD_WAIT: wait for mem_rvalid. Memory read latency is at least 1 cycle, so mem_rvalid during RD is ignored. Wait is unbounded; there is no timeout.
  - On mem_rvalid, register the merged word into mem_wdata and go to WR.
- Merge rules:
  - SB: byte lane addr[1:0] = st_data[7:0]; other lanes keep mem_rdata. Lane 00 -> bits 7:0, 01 -> 15:8, 10 -> 23:16, 11 -> 31:24.
  - SH: addr[1]=0 -> bits 15:0 = st_data[15:0]; addr[1]=1 -> bits 31:16 = st_data[15:0]. Other half keeps mem_rdata.
  - No sign or zero extension on stores; upper st_data bits are ignored.
- WR: mem_we=1, with mem_addr and mem_wdata held stable until mem_wack. mem_wack in the first WR cycle is legal. On mem_wack go to DONE, and mem_we drops the next cycle.
- DONE: st_done=1, st_err=0 for one cycle, then IDLE. A new request can be accepted the cycle after DONE.
- Minimum latency (accept at cycle 0, zero-wait memory):
  - SW: WR in cycle 1, st_done in cycle 2.
  - SB/SH with mem_rvalid 1 cycle after mem_re: RD 1, RD_WAIT 2, WR 3, st_done in cycle 4.
  - Error: st_done in cycle 1.
- mem_addr is held from RD through WR. Spurious mem_rvalid outside RD_WAIT and spurious mem_wack outside WR are ignored.
- st_valid while st_ready=0 is ignored; the requester holds the request until accepted.

Test Plan:
- SW aligned: funct=010, addr=0x100, st_data=0xDEADBEEF, mem_wack in the first WR cycle -> no mem_re; mem_we at cycle 1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; st_done=1, st_err=0 at cycle 2.
- SB all lanes: mem_rdata=0x11223344, st_data=0xFFFFFFAB, addr[1:0]=00/01/10/11 -> mem_wdata 0x112233AB / 0x1122AB44 / 0x11AB3344 / 0xAB223344; mem_addr has low bits 00.
- SH both halves: mem_rdata=0xAAAABBBB, st_data=0x12345678, addr=0x202 -> mem_wdata=0x5678BBBB; addr=0x200 -> 0xAAAA5678.
- Misaligned and illegal: SH with addr=0x201, SW with addr=0x102, funct=011 -> st_done=1, st_err=1 one cycle after accept; mem_re and mem_we stay 0; st_ready high the following cycle.
- Memory stalls: mem_rvalid delayed 5 cycles and mem_wack delayed 3 cycles -> mem_re is a single pulse; mem_we, mem_addr and mem_wdata stay stable across the whole wait; exactly one st_done.
- Reset mid-op: assert rst during RD_WAIT and during WR -> next edge: state IDLE, mem_we=0, st_done=0; a later mem_rvalid produces no write; a new SW is accepted normally.
